// File: rtl/game_ctrl.sv
// Game-flow sequencer: idle -> levels 1-4 -> win/fail, with ticket charging and pay-to-continue.
// Optional build macro CONTINUE_TIMEOUT_EN adds a FAIL-state timeout back to IDLE.
module game_ctrl #(
  parameter logic [31:0] LEVEL_TICKS    = 32'd500_000_000,
  parameter logic [6:0]  TICKET_COST    = 7'd10,
  parameter logic [31:0] CONTINUE_TICKS = 32'd1_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       quit,
  input  logic       fail,
  input  logic [6:0] total_money,
  output logic [3:0] state,
  output logic       ticket,
  output logic       deny,
  output logic       level_done
);

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_L1   = 4'd1;
  localparam logic [3:0] ST_L4   = 4'd4;
  localparam logic [3:0] ST_FAIL = 4'd5;
  localparam logic [3:0] ST_WIN  = 4'd6;

  logic [3:0]  state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  last_level_q, last_level_d;
  logic        ticket_q, ticket_d;
  logic        deny_q, deny_d;
  logic        level_done_q, level_done_d;
  logic        money_ok;
  logic        cont_expired;

  assign money_ok = (total_money >= TICKET_COST);

`ifdef CONTINUE_TIMEOUT_EN
  // >= so a denied start landing on the last tick still times out one cycle later
  assign cont_expired = (timer_q >= CONTINUE_TICKS - 32'd1);
`else
  logic unused_cfg;
  assign unused_cfg   = ^CONTINUE_TICKS;
  assign cont_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_level_d = last_level_q;
    ticket_d     = 1'b0;
    deny_d       = 1'b0;
    level_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = 32'd0;
        if (start) begin
          if (money_ok) begin
            ticket_d     = 1'b1;
            state_d      = ST_L1;
            last_level_d = 3'd1;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      4'd1, 4'd2, 4'd3, 4'd4: begin
        timer_d = timer_q + 32'd1;
        if (fail) begin
          state_d      = ST_FAIL;
          last_level_d = state_q[2:0];
          timer_d      = 32'd0;
        end else if (timer_q == LEVEL_TICKS - 32'd1) begin
          level_done_d = 1'b1;
          timer_d      = 32'd0;
          state_d      = (state_q == ST_L4) ? ST_WIN : state_q + 4'd1;
        end
      end
      ST_FAIL: begin
`ifdef CONTINUE_TIMEOUT_EN
        timer_d = timer_q + 32'd1;
`else
        timer_d = 32'd0;
`endif
        if (quit) begin
          state_d = ST_IDLE;
          timer_d = 32'd0;
        end else if (start && !fail) begin
          if (money_ok) begin
            ticket_d = 1'b1;
            state_d  = {1'b0, last_level_q};
            timer_d  = 32'd0;
          end else begin
            deny_d = 1'b1;
          end
        end else if (cont_expired) begin
          state_d = ST_IDLE;
          timer_d = 32'd0;
        end
      end
      ST_WIN: begin
        timer_d = 32'd0;
        if (start || quit) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= 32'd0;
      last_level_q <= 3'd1;
      ticket_q     <= 1'b0;
      deny_q       <= 1'b0;
      level_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_level_q <= last_level_d;
      ticket_q     <= ticket_d;
      deny_q       <= deny_d;
      level_done_q <= level_done_d;
    end
  end

  assign state      = state_q;
  assign ticket     = ticket_q;
  assign deny       = deny_q;
  assign level_done = level_done_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random traffic against a behavioural model.
// Honours CONTINUE_TIMEOUT_EN the same way the design does.
module tb_game_ctrl;
  localparam int LT   = 8;
  localparam int CT   = 16;
  localparam int COST = 10;

  logic       clk = 1'b0;
  logic       rst, start, quit, fail;
  logic [6:0] total_money;
  logic [3:0] state;
  logic       ticket, deny, level_done;

  game_ctrl #(
    .LEVEL_TICKS(32'd8),
    .TICKET_COST(7'd10),
    .CONTINUE_TICKS(32'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .quit(quit),
    .fail(fail),
    .total_money(total_money),
    .state(state),
    .ticket(ticket),
    .deny(deny),
    .level_done(level_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ld_count = 0;

  // Model: game phase, cycles left in the current level, cycles spent in FAIL, resume level
  int m_state, m_left, m_fail_cyc, m_resume;
  bit m_tk, m_dn, m_ld;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model(input bit r, input bit s, input bit q, input bit f, input int money);
    bit expired;
    expired = 1'b0;
    m_tk = 0; m_dn = 0; m_ld = 0;
    if (r) begin
      m_state = 0; m_left = LT; m_fail_cyc = 0; m_resume = 1;
    end else begin
      case (m_state)
        0: if (s) begin
          if (money >= COST) begin
            m_tk = 1; m_state = 1; m_left = LT; m_resume = 1;
          end else m_dn = 1;
        end
        1, 2, 3, 4: begin
          if (f) begin
            m_resume = m_state; m_state = 5; m_fail_cyc = 0;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_ld = 1;
              m_state = (m_state == 4) ? 6 : m_state + 1;
              m_left = LT;
            end
          end
        end
        5: begin
`ifdef CONTINUE_TIMEOUT_EN
          expired = (m_fail_cyc >= CT - 1);
          m_fail_cyc++;
`endif
          if (q) m_state = 0;
          else if (s && !f) begin
            if (money >= COST) begin
              m_tk = 1; m_state = m_resume; m_left = LT;
            end else m_dn = 1;
          end else if (expired) m_state = 0;
        end
        6: if (s || q) m_state = 0;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic step(input bit r, input bit s, input bit q, input bit f, input int money);
    @(negedge clk);
    rst = r; start = s; quit = q; fail = f; total_money = 7'(money);
    @(posedge clk);
    model(r, s, q, f, money);
    #1;
    check("state", int'(state), m_state);
    check("ticket", int'(ticket), int'(m_tk));
    check("deny", int'(deny), int'(m_dn));
    check("level_done", int'(level_done), int'(m_ld));
    if (level_done) ld_count++;
    if (r || s || q)
      $display("txn rst=%0d start=%0d quit=%0d fail=%0d money=%0d -> state=%0d ticket=%0d deny=%0d",
               r, s, q, f, money, state, ticket, deny);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; quit = 1'b0; fail = 1'b0; total_money = 7'd0;
    step(1, 0, 0, 0, 0);

    // Money below, then above the ticket price
    step(0, 1, 0, 0, 9);
    check("deny_idle_state", int'(state), 0);
    step(0, 1, 0, 0, 20);
    check("start_ticket", int'(ticket), 1);

    // Full run to WIN
    ld_count = 0;
    idle(4 * LT);
    check("level_done_count", ld_count, 4);
    check("win_state", int'(state), 6);
    step(0, 1, 0, 0, 0);

    // Exact-price start, fail on the last tick of LEVEL3
    step(0, 1, 0, 0, 10);
    idle(2 * LT);
    idle(LT - 1);
    step(0, 0, 0, 1, 0);
    check("fail_prio_state", int'(state), 5);
    check("fail_prio_no_done", int'(level_done), 0);
    step(0, 1, 0, 1, 50);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 5);
    step(0, 1, 0, 0, 15);
    check("continue_level", int'(state), 3);
    idle(LT - 1);
    check("l3_full_hold", int'(state), 3);
    idle(1);
    check("l4_after_hold", int'(state), 4);
    step(0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 50);
    check("quit_wins_no_ticket", int'(ticket), 0);

    // Reset mid-level and during a ticket cycle
    step(0, 1, 0, 0, 20);
    idle(LT + 3);
    step(1, 1, 0, 0, 20);
    step(0, 1, 0, 0, 20);
    step(1, 1, 0, 0, 20);

    // FAIL with no input
    step(0, 1, 0, 0, 20);
    step(0, 0, 0, 1, 0);
    idle(CT);
`ifdef CONTINUE_TIMEOUT_EN
    check("timeout_at_16", int'(state), 0);
`else
    check("no_timeout_16", int'(state), 5);
`endif
    idle(100 - CT);
`ifdef CONTINUE_TIMEOUT_EN
    check("timeout_at_100", int'(state), 0);
`else
    check("no_timeout_100", int'(state), 5);
`endif
    step(0, 0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, s, q, f;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 5) == 0);
      q = ($urandom_range(0, 19) == 0);
      if (m_state >= 1 && m_state <= 4) f = ($urandom_range(0, 29) == 0);
      else if (m_state == 5) f = ($urandom_range(0, 2) == 0);
      else f = 1'($urandom_range(0, 1));
      step(r, s, q, f, int'($urandom_range(0, 25)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
